dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter ADDR_W, default 11, half-word address width; the array holds 2**ADDR_W 16-bit entries.
REQ-002 Parameter WORD_W, default 32, request/response data width; fixed at 2x16.
REQ-003 Port clk, input, 1, single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1, reset; asynchronous, active-high.
REQ-005 Port req_valid, input, 1, request present; sampled only in IDLE.
REQ-006 Port req_we, input, 1, 1 = write word, 0 = read word.
REQ-007 Port req_addr, input, ADDR_W, half-word address of the low half; bit 0 selects alignment.
REQ-008 Port req_wdata, input, 32, write data; [15:0] goes to the even half, [31:16] to the odd half.
REQ-009 Port busy, output, 1, high whenever the FSM is not in IDLE.
REQ-010 Port resp_valid, output, 1, one-cycle completion pulse for both reads and writes.
REQ-011 Port resp_rdata, output, 32, read data; valid while resp_valid is high.
REQ-012 Port resp_err, output, 1, misaligned-access flag, qualified by resp_valid.

Function
REQ-013 The FSM shall have four states: IDLE, LO, HI, RESP.
REQ-014 IDLE transitions:
  - req_valid=1 -> LO, latching req_we, req_addr and req_wdata.
  - req_valid=0 -> stays in IDLE.
REQ-015 In LO, the array shall access entry {addr[ADDR_W-1:1],1'b0}:
  - write: store wdata[15:0];
  - read: capture into resp_rdata[15:0].
  - Next state is HI.
REQ-016 In HI, the same access shall apply to entry {addr[ADDR_W-1:1],1'b1} with wdata[31:16] / resp_rdata[31:16]; next state is RESP.
REQ-017 RESP shall assert resp_valid for exactly one cycle, then return to IDLE.
REQ-018 Latency: resp_valid shall be high in the third cycle after the accepting edge, one cycle per state; back-to-back requests are accepted every 4 cycles at most.
REQ-019 req_valid and all req_* inputs shall be ignored while busy=1; latched values shall not change mid-transaction.
REQ-020 For writes, resp_rdata shall hold its previous value; only reads update it.
REQ-021 A write followed by a read of the same address shall return the written word, since the write's halves complete before RESP.
REQ-022 Address wrap: the top even address 2**ADDR_W-2 pairs with 2**ADDR_W-1; no carry shall propagate beyond ADDR_W.
REQ-023 Array read data shall be registered, so the array maps to synchronous-read RAM.

Reset
REQ-024 rst=1 shall asynchronously force:
  - state = IDLE;
  - busy = 0, resp_valid = 0, resp_rdata = 0, resp_err = 0;
  - latched request registers = 0.
REQ-025 Array contents shall not be reset; contents after power-up are undefined.
REQ-026 Reset asserted in HI after a write in LO shall leave the low half written and the high half unchanged; no response shall be issued for the aborted transaction.

Configuration
REQ-027 Macro DMEM_MISALIGN_ERR_EN:
  - Defined: an accepted request with req_addr[0]=1 shall go IDLE -> RESP directly, perform no array access, and present resp_err=1 with resp_rdata unchanged.
  - Undefined: req_addr[0] shall be ignored (treated as 0) and resp_err shall be tied to 0.

Verification
REQ-028 After reset, write 0xDEADBEEF to addr 0x004, then read addr 0x004 -> resp_rdata=0xDEADBEEF with resp_valid exactly 3 cycles after each accepting edge, and resp_err=0.
REQ-029 Write 0x12345678 to addr 0x7FE, then read 0x7FE -> 0x12345678; entry 0x000 is unchanged, confirming no wrap-around corruption.
REQ-030 Hold req_valid=1 continuously with alternating addresses -> requests accepted only in IDLE, one every 4 cycles; busy=1 for exactly 3 cycles per request.
REQ-031 Write 0xAAAA5555 to addr 0x010, then assert rst for 1 cycle while in HI during a write of 0xFFFF0000 to 0x010, then read 0x010 -> 0xAAAA0000; no resp_valid for the aborted write.
REQ-032 With DMEM_MISALIGN_ERR_EN defined, read addr 0x005 -> resp_valid 1 cycle after acceptance with resp_err=1 and memory untouched; with it undefined, the same read returns the word at 0x004 and resp_err=0.

Source files
------------

// File: rtl/dmem_responder.sv
// Word-wide request responder over a 16-bit half-word array: each request is
// split into a low and a high half-word access. Optional: DMEM_MISALIGN_ERR_EN.
module dmem_responder #(
  parameter int ADDR_W = 11,
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              busy,
  output logic              resp_valid,
  output logic [WORD_W-1:0] resp_rdata,
  output logic              resp_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                we_q, we_d;
  logic [ADDR_W-2:0]   pair_q, pair_d;
  logic [WORD_W-1:0]   wdata_q, wdata_d;
  logic                busy_q, busy_d;
  logic                valid_q, valid_d;
  logic                err_q, err_d;
  logic [15:0]         rd_lo_q, rd_hi_q;
  logic [15:0]         mem [0:(2**ADDR_W)-1];

  logic                misalign_s;
  logic                mem_en_s;
  logic [ADDR_W-1:0]   mem_addr_s;
  logic [15:0]         mem_wdata_s;

`ifdef DMEM_MISALIGN_ERR_EN
  assign misalign_s = req_addr[0];
`else
  // Bit 0 is a don't-care here: both halves come from the pair address.
  assign misalign_s = req_addr[0] & 1'b0;
`endif

  // Next-state, request latch and registered-output decode
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    pair_d  = pair_q;
    wdata_d = wdata_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          pair_d  = req_addr[ADDR_W-1:1];
          wdata_d = req_wdata;
          if (misalign_s) begin
            state_d = RESP;
            err_d   = 1'b1;
          end else begin
            state_d = LO;
          end
        end else begin
          state_d = IDLE;
        end
      end
      LO:      state_d = HI;
      HI:      state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d  = (state_d != IDLE);
    valid_d = (state_d == RESP);
  end

  // Half-word array port: even entry in LO, odd entry in HI
  always_comb begin
    mem_en_s    = (state_q == LO) || (state_q == HI);
    mem_addr_s  = {pair_q, (state_q == HI)};
    mem_wdata_s = (state_q == HI) ? wdata_q[31:16] : wdata_q[15:0];
  end

  // Control and request registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      pair_q  <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      pair_q  <= pair_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  // Array write port; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (mem_en_s && we_q) begin
      mem[mem_addr_s] <= mem_wdata_s;
    end
  end

  // Registered array read halves, updated only by reads
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_lo_q <= 16'h0000;
      rd_hi_q <= 16'h0000;
    end else if (mem_en_s && !we_q) begin
      if (state_q == LO) begin
        rd_lo_q <= mem[mem_addr_s];
      end else begin
        rd_hi_q <= mem[mem_addr_s];
      end
    end
  end

  assign busy       = busy_q;
  assign resp_valid = valid_q;
  assign resp_err   = err_q;
  assign resp_rdata = {rd_hi_q, rd_lo_q};

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder against a half-word array
// model; honours DMEM_MISALIGN_ERR_EN when defined at compile time.
module tb_dmem_responder;
  localparam int AW = 11;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          busy;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          resp_err;

  dmem_responder #(.ADDR_W(AW), .WORD_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .busy       (busy),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  always #5 clk = ~clk;

  logic [15:0] model [0:(2**AW)-1];
  logic [31:0] last_rd;
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_word(input logic [AW-1:0] a);
    logic [AW-1:0] e;
    e = {a[AW-1:1], 1'b0};
    return {model[e + 11'd1], model[e]};
  endfunction

  function automatic bit is_misaligned(input logic [AW-1:0] a);
    bit m;
    m = 1'b0;
`ifdef DMEM_MISALIGN_ERR_EN
    m = a[0];
`endif
    return m;
  endfunction

  // One full request; junk (with req_valid high) is driven while busy.
  task automatic transact(input logic we, input logic [AW-1:0] a, input logic [31:0] wd);
    bit            mis;
    int            lat;
    int            exp_lat;
    logic [AW-1:0] e;
    mis = is_misaligned(a);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (resp_valid) begin
        req_valid = 1'b0;
      end else begin
        req_valid = 1'b1;
        req_we    = 1'($urandom);
        req_addr  = AW'($urandom);
        req_wdata = $urandom;
      end
    end while (!resp_valid && lat < 8);
    exp_lat = mis ? 1 : 3;
    e = {a[AW-1:1], 1'b0};
    if (!mis && we) begin
      model[e]         = wd[15:0];
      model[e + 11'd1] = wd[31:16];
    end else if (!mis) begin
      last_rd = model_word(a);
    end
    check("latency", 32'(lat), 32'(exp_lat));
    check("resp_err", {31'd0, resp_err}, {31'd0, mis});
    check("resp_rdata", resp_rdata, last_rd);
    req_valid = 1'b0;
    @(negedge clk);
    check("pulse_end", {30'd0, resp_valid, busy}, 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] pend;
    logic [AW-1:0] a;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = 32'd0;
    last_rd = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_err", {31'd0, resp_err}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 32; i++) transact(1'b1, AW'(2 * i), $urandom);
    transact(1'b1, 11'h7FE, $urandom);

    transact(1'b1, 11'h004, 32'hDEADBEEF);
    transact(1'b0, 11'h004, 32'd0);
    check("rd_004", resp_rdata, 32'hDEADBEEF);

    transact(1'b1, 11'h7FE, 32'h12345678);
    transact(1'b0, 11'h7FE, 32'd0);
    check("rd_7fe", resp_rdata, 32'h12345678);
    transact(1'b0, 11'h000, 32'd0);

    // Reset while the high half of a write is pending
    transact(1'b1, 11'h010, 32'hAAAA5555);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 11'h010; req_wdata = 32'hFFFF0000;
    @(negedge clk);
    req_valid = 1'b0;
    check("abort_lo_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model[11'h010] = 16'h0000;
    last_rd = 32'd0;
    for (int i = 0; i < 4; i++) begin
      check("abort_no_resp", {31'd0, resp_valid}, 32'd0);
      @(negedge clk);
    end
    transact(1'b0, 11'h010, 32'd0);
    check("rd_010", resp_rdata, 32'hAAAA0000);

    transact(1'b0, 11'h005, 32'd0);
    transact(1'b0, 11'h004, 32'd0);
    check("rd_004_again", resp_rdata, 32'hDEADBEEF);

    // Continuous req_valid: one acceptance every fourth cycle
    pend = '0;
    for (int n = 0; n < 16; n++) begin
      @(negedge clk);
      check("pipe_busy", {31'd0, busy}, {31'd0, (n % 4) != 0});
      check("pipe_valid", {31'd0, resp_valid}, {31'd0, (n % 4) == 3});
      if (n % 4 == 3) begin
        last_rd = model_word(pend);
        check("pipe_rdata", resp_rdata, last_rd);
      end
      a = AW'(2 * $urandom_range(0, 31));
      req_valid = (n < 15); req_we = 1'b0; req_addr = a; req_wdata = $urandom;
      if (n % 4 == 0) pend = a;
    end
    req_valid = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 5) == 0) a = AW'(11'h7FE + 11'($urandom_range(0, 1)));
      else a = AW'($urandom_range(0, 63));
      transact(1'($urandom), a, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
